ram_io_responder: RTL and testbench

Responder side of the byte-wide RAM port driven by the core's memory controller. It holds the byte-addressed main memory and decodes the I/O window (`ram_addr[17:16] == 2'b11`). Writes to that window go to a TX FIFO that drains to the host byte stream, and reads from it pop an RX FIFO. The block sits at the top level between the CPU memory controller and the host/UART link, and produces the `io_buffer_full` back-pressure the controller consumes.

---
 rtl/ram_io_responder_pkg.sv | 22 ++
 rtl/ram_io_responder_fifo.sv | 54 +++++
 rtl/ram_io_responder.sv | 131 +++++++++++++
 tb/tb_ram_io_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared bus widths, I/O window decode constants and the status-byte layout
// for ram_io_responder.
package ram_io_responder_pkg;

  localparam int ByteBus    = 8;
  localparam int MemAddrBus = 32;

  localparam logic [1:0] IoWindow = 2'b11;
  localparam logic [2:0] IoData   = 3'h0;
  localparam logic [2:0] IoCtrl   = 3'h4;

  typedef struct packed {
    logic       tx_overflow;
    logic       rx_nonempty;
    logic [5:0] tx_count;
  } io_status_t;

  function automatic logic in_io_window(input logic [MemAddrBus-1:0] addr);
    return addr[17:16] == IoWindow;
  endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: power-of-two byte FIFO, push and pop allowed in the same cycle;
// a same-cycle pop frees the slot for a push while full.
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-wide RAM responder: main memory plus an I/O window with TX/RX FIFOs.
// The RX FIFO and host receive handshake are built only when IO_RX_EN is defined.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ram_r_w,
  input  logic [MemAddrBus-1:0] ram_addr,
  input  logic [ByteBus-1:0]    ram_w_data,
  output logic [ByteBus-1:0]    ram_r_data,
  output logic                  io_buffer_full,
  output logic [ByteBus-1:0]    io_tx_data,
  output logic                  io_tx_valid,
  input  logic                  io_tx_ready,
  input  logic [ByteBus-1:0]    io_rx_data,
  input  logic                  io_rx_valid,
  output logic                  io_rx_ready,
  output logic                  sim_halt
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [ByteBus-1:0] mem_q [2**RAM_AW];
  logic [ByteBus-1:0] mem_rd_q, io_rd_q, io_rd_d, rx_head;
  logic               rd_sel_mem_q, tx_overflow_q, halt_q;
  logic               io_sel, wr_mem, rd_mem, wr_tx, rd_rx, wr_ctrl, rd_io;
  logic               tx_pop, tx_full, tx_empty, rx_nonempty;
  logic [TX_CW-1:0]   tx_count;
  logic [2:0]         io_off;
  io_status_t         status;
  logic               unused_addr;

  assign unused_addr = ^ram_addr[MemAddrBus-1:18];

  assign io_sel  = in_io_window(ram_addr);
  assign io_off  = ram_addr[2:0];
  assign wr_mem  = !io_sel && ram_r_w;
  assign rd_mem  = !io_sel && !ram_r_w;
  assign rd_io   = io_sel && !ram_r_w;
  assign wr_tx   = io_sel && ram_r_w && (io_off == IoData);
  assign rd_rx   = rd_io && (io_off == IoData);
  assign wr_ctrl = io_sel && ram_r_w && (io_off == IoCtrl);

  assign tx_pop         = io_tx_valid && io_tx_ready;
  assign io_tx_valid    = !tx_empty;
  assign io_buffer_full = (tx_count >= TX_CW'(TX_DEPTH - 1));
  assign sim_halt       = halt_q;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_tx),
    .pop_i   (tx_pop),
    .din_i   (ram_w_data),
    .dout_o  (io_tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

`ifdef IO_RX_EN
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  logic             rx_full, rx_empty;
  logic [RX_CW-1:0] rx_count;
  logic             unused_rx_count;

  assign unused_rx_count = ^rx_count;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (io_rx_valid && io_rx_ready),
    .pop_i   (rd_rx),
    .din_i   (io_rx_data),
    .dout_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign io_rx_ready = !rx_full;
  assign rx_nonempty = !rx_empty;
`else
  logic unused_rx_in;
  assign unused_rx_in = ^{io_rx_data, io_rx_valid, rd_rx};
  assign rx_head      = '0;
  assign io_rx_ready  = 1'b0;
  assign rx_nonempty  = 1'b0;
`endif

  assign status = '{tx_overflow: tx_overflow_q, rx_nonempty: rx_nonempty,
                    tx_count: 6'(tx_count)};

  always_comb begin
    io_rd_d = '0;
    case (io_off)
      IoData:  io_rd_d = rx_nonempty ? rx_head : '0;
      IoCtrl:  io_rd_d = status;
      default: io_rd_d = '0;
    endcase
  end

  // Memory array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[ram_addr[RAM_AW-1:0]] <= ram_w_data;
    if (rd_mem) mem_rd_q <= mem_q[ram_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_mem_q  <= 1'b0;
      io_rd_q       <= '0;
      tx_overflow_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      if (!ram_r_w) rd_sel_mem_q <= rd_mem;
      if (rd_io)    io_rd_q      <= io_rd_d;
      if (wr_tx && tx_full && !tx_pop) tx_overflow_q <= 1'b1;
      if (wr_ctrl)  halt_q       <= 1'b1;
    end
  end

  // Read data holds between reads because both sources only load on a read.
  assign ram_r_data = rd_sel_mem_q ? mem_rd_q : io_rd_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder with read-data and TX-byte scoreboards.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_r_w;
  logic [31:0] ram_addr;
  logic [7:0]  ram_w_data;
  logic [7:0]  ram_r_data;
  logic        io_buffer_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic        sim_halt;

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_r_w        (ram_r_w),
    .ram_addr       (ram_addr),
    .ram_w_data     (ram_w_data),
    .ram_r_data     (ram_r_data),
    .io_buffer_full (io_buffer_full),
    .io_tx_data     (io_tx_data),
    .io_tx_valid    (io_tx_valid),
    .io_tx_ready    (io_tx_ready),
    .io_rx_data     (io_rx_data),
    .io_rx_valid    (io_rx_valid),
    .io_rx_ready    (io_rx_ready),
    .sim_halt       (sim_halt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ram_r_w    = 1'b0;
    ram_addr   = 32'h0;
    ram_w_data = 8'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    ram_r_w    = 1'b1;
    ram_addr   = a;
    ram_w_data = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    ram_r_w  = 1'b0;
    ram_addr = a;
    rd_q.push_back(exp);
    step();
    idle();
    check(tag, ram_r_data, rd_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    io_tx_ready = 1'b0;
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h0;
    repeat (3) step();

    check("rst_rdata", ram_r_data, 8'h00);
    check("rst_tx_valid", {7'h0, io_tx_valid}, 8'h00);
    check("rst_buf_full", {7'h0, io_buffer_full}, 8'h00);
    check("rst_halt", {7'h0, sim_halt}, 8'h00);
`ifdef IO_RX_EN
    check("rst_rx_ready", {7'h0, io_rx_ready}, 8'h01);
`else
    check("rst_rx_ready", {7'h0, io_rx_ready}, 8'h00);
`endif
    rst_n = 1'b1;

    // Memory: write then read next cycle, top of memory, hold across writes.
    wr(32'h00010, 8'hA5);
    rd(32'h00010, 8'hA5, "mem_rw");
    wr(32'h1FFFF, 8'h3C);
    rd(32'h1FFFF, 8'h3C, "mem_top");
    rd(32'h00010, 8'hA5, "mem_reread");
    wr(32'h00020, 8'h77);
    check("rdata_held", ram_r_data, 8'hA5);
    rd(32'h00020, 8'h77, "mem_second");

    rd(32'h30004, 8'h00, "ctrl_idle");
    rd(32'h30002, 8'h00, "io_other_rd");
    wr(32'h30001, 8'hFF);
    rd(32'h30004, 8'h00, "ctrl_after_ignored");

    // TX fill with host stalled.
    for (int i = 0; i < 15; i++) begin
      tx_q.push_back(8'(8'h10 + i));
      wr(32'h30000, 8'(8'h10 + i));
      if (i == 13) check("buf_full_14", {7'h0, io_buffer_full}, 8'h00);
    end
    check("buf_full_15", {7'h0, io_buffer_full}, 8'h01);
    check("tx_valid_fill", {7'h0, io_tx_valid}, 8'h01);
    check("tx_head_fill", io_tx_data, 8'h10);
    tx_q.push_back(8'h1F);
    wr(32'h30000, 8'h1F);
    rd(32'h30004, 8'h10, "ctrl_count16");
    wr(32'h30000, 8'hEE);
    rd(32'h30004, 8'h90, "ctrl_overflow");

    io_tx_ready = 1'b1;
    for (int c = 0; c < 40 && tx_q.size() > 0; c++) begin
      if (io_tx_valid) check("tx_drain", io_tx_data, tx_q.pop_front());
      step();
    end
    check("tx_drain_left", 8'(tx_q.size()), 8'h00);
    check("tx_valid_drained", {7'h0, io_tx_valid}, 8'h00);
    check("buf_full_drained", {7'h0, io_buffer_full}, 8'h00);
    rd(32'h30004, 8'h80, "ctrl_sticky_ovf");

    // Pass-through with host ready: count stays at one.
    tx_q.push_back(8'h41);
    wr(32'h30000, 8'h41);
    check("pt_valid_a", {7'h0, io_tx_valid}, 8'h01);
    check("pt_data_a", io_tx_data, tx_q.pop_front());
    tx_q.push_back(8'h42);
    wr(32'h30000, 8'h42);
    check("pt_valid_b", {7'h0, io_tx_valid}, 8'h01);
    check("pt_data_b", io_tx_data, tx_q.pop_front());
    step();
    check("pt_valid_end", {7'h0, io_tx_valid}, 8'h00);
    rd(32'h30004, 8'h80, "ctrl_pt_count");
    io_tx_ready = 1'b0;

`ifdef IO_RX_EN
    check("rx_ready_empty", {7'h0, io_rx_ready}, 8'h01);
    io_rx_valid = 1'b1;
    io_rx_data  = 8'h31;
    step();
    io_rx_data  = 8'h32;
    step();
    io_rx_valid = 1'b0;
    rd(32'h30004, 8'hC0, "ctrl_rx_nonempty");
    rd(32'h30000, 8'h31, "rx_pop1");
    rd(32'h30000, 8'h32, "rx_pop2");
    rd(32'h30000, 8'h00, "rx_pop_empty");
    rd(32'h30004, 8'h80, "ctrl_rx_empty");
    for (int i = 0; i < 9; i++) begin
      io_rx_valid = 1'b1;
      io_rx_data  = 8'(8'h50 + i);
      step();
    end
    io_rx_valid = 1'b0;
    check("rx_ready_full", {7'h0, io_rx_ready}, 8'h00);
    for (int i = 0; i < 8; i++) rd(32'h30000, 8'(8'h50 + i), "rx_full_pop");
    rd(32'h30000, 8'h00, "rx_full_extra");
    check("rx_ready_after", {7'h0, io_rx_ready}, 8'h01);
`else
    check("rx_ready_off", {7'h0, io_rx_ready}, 8'h00);
    io_rx_valid = 1'b1;
    io_rx_data  = 8'h31;
    step();
    io_rx_valid = 1'b0;
    rd(32'h30000, 8'h00, "rx_off_data");
    rd(32'h30004, 8'h80, "ctrl_rx_off");
`endif

    // Halt is sticky.
    check("halt_before", {7'h0, sim_halt}, 8'h00);
    wr(32'h30004, 8'h5A);
    check("halt_set", {7'h0, sim_halt}, 8'h01);
    repeat (5) step();
    check("halt_sticky", {7'h0, sim_halt}, 8'h01);

    // Reset mid-burst with a read issued but not yet sampled.
    for (int i = 0; i < 15; i++) wr(32'h30000, 8'(8'h60 + i));
    check("burst_full", {7'h0, io_buffer_full}, 8'h01);
    ram_r_w  = 1'b0;
    ram_addr = 32'h00010;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", {7'h0, io_tx_valid}, 8'h00);
    check("mid_rst_buf_full", {7'h0, io_buffer_full}, 8'h00);
    check("mid_rst_halt", {7'h0, sim_halt}, 8'h00);
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    check("post_rst_rdata", ram_r_data, 8'h00);
    rd(32'h30004, 8'h00, "post_rst_ctrl");
    rd(32'h00010, 8'hA5, "post_rst_mem");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
